frame_serializer: RTL

- Transmit-side stage that sits directly upstream of the lane deserializer.
- Buffers parallel payload words in a small FIFO and frames each one as a DATA_WIDTH-bit symbol: a leading 0 start bit followed by the payload, MSB first.
- Drives the symbols onto a single serial line; idle level is 1.
- Emits frames back-to-back with no gap, so the downstream deserializer stays word-aligned.

---
 rtl/frame_serializer_if.sv | 29 ++
 rtl/frame_serializer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/frame_serializer_if.sv
// -----------------------------------------------------------------------------
// frame_serializer_if
// Parallel payload handshake into the frame serializer.
//   in_data  : payload word (DATA_WIDTH-1 bits), producer -> serializer
//   in_valid : in_data holds a word to be buffered, producer -> serializer
//   in_ready : serializer FIFO has room for a word, serializer -> producer
// A word transfers on a clock edge where in_valid && in_ready.
// -----------------------------------------------------------------------------
interface frame_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-2:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  // Producer side drives the word and its valid flag
  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  // Serializer side consumes the word and reports FIFO room
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/frame_serializer.sv
// -----------------------------------------------------------------------------
// frame_serializer
// Buffers payload words in a small FIFO and sends each one on a single serial
// line as a DATA_WIDTH-bit frame: a 0 start bit followed by the payload,
// MSB first. The idle line level is 1. Frames are sent back-to-back with no
// gap so that the downstream deserializer stays word-aligned.
//
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : asynchronous assert, active-low reset
//   enable     : permits new frames to start; never aborts a running frame
//   in_bus     : payload handshake (in_data / in_valid / in_ready)
//   serial_out : registered serial line
//   busy       : a frame is on the line
//   frame_done : one-cycle pulse coincident with a frame's last bit
//   fifo_level : words currently buffered
// -----------------------------------------------------------------------------
module frame_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  frame_serializer_if.slave             in_bus,
  output logic                          serial_out,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = DATA_WIDTH - 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] LAST_CNT     = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] PRE_LAST_CNT = CW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   LEVEL_ZERO   = {(AW + 1){1'b0}};
  localparam logic [AW:0]   LEVEL_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   LEVEL_FULL   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ZERO     = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE      = AW'(1);
  localparam logic [PW-1:0] WORD_ZERO    = {PW{1'b0}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [PW-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;

  state_t        state_r;
  logic [PW-1:0] shift_r;
  logic [CW-1:0] bit_cnt_r;

  logic          push_s;
  logic          pop_s;

  // Room is judged from the registered level only, so in_ready never depends
  // on whether a pop happens in the same cycle.
  assign in_bus.in_ready = (level_r < LEVEL_FULL);
  assign fifo_level      = level_r;

  // Push/pop decisions for this cycle
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    push_s = in_bus.in_valid && (level_r < LEVEL_FULL);
    // A new frame may start from IDLE, or on the last bit of the current one
    // so consecutive frames abut with no idle bit.
    if ((state_r == IDLE) || (bit_cnt_r == LAST_CNT)) begin
      pop_s = enable && (level_r != LEVEL_ZERO);
    end else begin
      pop_s = 1'b0;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_bus.in_data;
    end
  end

  // FIFO pointers and level; simultaneous push and pop leave the level alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LEVEL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Framing FSM with registered line, busy and frame_done outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      shift_r    <= WORD_ZERO;
      bit_cnt_r  <= CNT_ZERO;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          frame_done <= 1'b0;
          if (pop_s) begin
            shift_r    <= mem_r[rd_ptr_r];
            serial_out <= 1'b0;
            bit_cnt_r  <= CNT_ONE;
            busy       <= 1'b1;
            state_r    <= SHIFT;
          end else begin
            serial_out <= 1'b1;
            bit_cnt_r  <= CNT_ZERO;
            busy       <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt_r < LAST_CNT) begin
            serial_out <= shift_r[PW-1];
            shift_r    <= {shift_r[PW-2:0], 1'b0};
            bit_cnt_r  <= bit_cnt_r + CNT_ONE;
            // Pulse lands with the last payload bit on the line
            frame_done <= (bit_cnt_r == PRE_LAST_CNT);
          end else if (pop_s) begin
            shift_r    <= mem_r[rd_ptr_r];
            serial_out <= 1'b0;
            bit_cnt_r  <= CNT_ONE;
            frame_done <= 1'b0;
          end else begin
            serial_out <= 1'b1;
            bit_cnt_r  <= CNT_ZERO;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          serial_out <= 1'b1;
          bit_cnt_r  <= CNT_ZERO;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule
